axi_hp_wr_framer: RTL and testbench

//  Upstream stage of the AXI HP write master. Buffers a free-running sample stream in a FIFO.

---
 rtl/axi_hp_pkg.sv | 13 +
 rtl/sync_fifo_fwft.sv | 60 ++++++
 rtl/axi_hp_wr_framer.sv | 154 +++++++++++++++
 tb/tb_axi_hp_wr_framer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_hp_pkg.sv
// Shared definitions for the AXI HP write path (framer and write master).
package axi_hp_pkg;

   localparam int DATA_W_DEF    = 64;
   localparam int BURST_LEN_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_DONE  = 2'd2
   } wr_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; head word visible on o_rd_data.
module sync_fifo_fwft #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 16,
   parameter int LW     = $clog2(DEPTH) + 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_wr_valid,
   input  logic              i_rd_en,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_full,
   output logic              o_empty,
   output logic [LW-1:0]     o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wptr;
   logic [AW-1:0]     rptr;
   logic [LW-1:0]     cnt;
   logic              wr;
   logic              rd;

   assign o_full    = (cnt == LW'(DEPTH));
   assign o_empty   = (cnt == '0);
   assign o_level   = cnt;
   assign o_rd_data = mem[rptr];
   assign wr        = i_wr_valid & ~o_full;
   assign rd        = i_rd_en & ~o_empty;

   always_ff @(posedge i_clk) begin
      if (wr) begin
         mem[wptr] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (wr) begin
            wptr <= wptr + AW'(1);
         end
         if (rd) begin
            rptr <= rptr + AW'(1);
         end
         unique case ({wr, rd})
            2'b10:   cnt <= cnt + LW'(1);
            2'b01:   cnt <= cnt - LW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/axi_hp_wr_framer.sv
// Frames a free-running sample stream into unbroken BURST_LEN-beat bursts
// for the AXI HP write master; flush pads a partial burst and ends the frame.
module axi_hp_wr_framer
   import axi_hp_pkg::*;
#(
   parameter int                DATA_W       = DATA_W_DEF,
   parameter int                BURST_LEN    = BURST_LEN_DEF,
   parameter int                FIFO_DEPTH   = 16,
   parameter int                FRAME_BURSTS = 8,
   parameter logic [DATA_W-1:0] PAD_WORD     = '0
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [DATA_W-1:0]             S_IN_tdata,
   input  logic                          S_IN_tvalid,
   output logic                          S_IN_tready,
   input  logic                          i_flush,
   output logic [DATA_W-1:0]             M_WR_tdata,
   output logic                          M_WR_tvalid,
   output logic                          M_WR_tlast,
   input  logic                          M_WR_tready,
   output logic                          o_wr_done,
   output logic [$clog2(FIFO_DEPTH):0]   o_level,
   output logic [15:0]                   o_burst_cnt
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int PW = $clog2(BURST_LEN) + 1;

   localparam logic [LW-1:0] LVL_BURST  = LW'(BURST_LEN);
   localparam logic [BW-1:0] BEAT_LAST  = BW'(BURST_LEN - 1);
   localparam logic [PW-1:0] PAD_NONE   = PW'(BURST_LEN);
   localparam logic [15:0]   FRAME_LAST = 16'(FRAME_BURSTS);

   wr_state_t         state_q;
   wr_state_t         state_d;
   logic [BW-1:0]     beat_q;
   logic [BW-1:0]     beat_d;
   logic [15:0]       burst_q;
   logic [15:0]       burst_d;
   logic [PW-1:0]     pad_q;
   logic [PW-1:0]     pad_d;
   logic              flush_q;
   logic              flush_d;
   logic              tvalid_q;

   logic [DATA_W-1:0] head;
   logic [LW-1:0]     level;
   logic              full;
   logic              empty;
   logic              hs;
   logic              real_beat;
   logic              last_beat;
   logic              pop;

   sync_fifo_fwft #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH),
      .LW     (LW)
   ) u_fifo (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_wr_data  (S_IN_tdata),
      .i_wr_valid (S_IN_tvalid),
      .i_rd_en    (pop),
      .o_rd_data  (head),
      .o_full     (full),
      .o_empty    (empty),
      .o_level    (level)
   );

   assign hs        = tvalid_q & M_WR_tready;
   assign real_beat = (PW'(beat_q) < pad_q);
   assign last_beat = (beat_q == BEAT_LAST);
   assign pop       = hs & real_beat;

   assign S_IN_tready = ~i_rst & ~full;
   assign M_WR_tvalid = tvalid_q;
   assign M_WR_tdata  = real_beat ? head : PAD_WORD;
   assign M_WR_tlast  = tvalid_q & last_beat;
   assign o_wr_done   = (state_q == ST_DONE);
   assign o_level     = level;
   assign o_burst_cnt = burst_q;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      burst_d = burst_q;
      pad_d   = pad_q;
      flush_d = flush_q | i_flush;
      unique case (state_q)
         ST_IDLE: begin
            if (level >= LVL_BURST) begin
               state_d = ST_BURST;
               pad_d   = PAD_NONE;
            end else if (flush_q && !empty) begin
               state_d = ST_BURST;
               pad_d   = PW'(level);
            end else if (flush_q) begin
               // Empty flush with nothing sent closes no frame.
               if (burst_q != '0) begin
                  state_d = ST_DONE;
               end else begin
                  flush_d = i_flush;
               end
            end
         end
         ST_BURST: begin
            if (hs) begin
               if (last_beat) begin
                  beat_d  = '0;
                  burst_d = burst_q + 16'd1;
                  if (burst_q + 16'd1 == FRAME_LAST
                      || pad_q != PAD_NONE) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  beat_d = beat_q + BW'(1);
               end
            end
         end
         ST_DONE: begin
            burst_d = '0;
            flush_d = i_flush;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         beat_q   <= '0;
         burst_q  <= '0;
         pad_q    <= PAD_NONE;
         flush_q  <= 1'b0;
         tvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         burst_q  <= burst_d;
         pad_q    <= pad_d;
         flush_q  <= flush_d;
         tvalid_q <= (state_d == ST_BURST);
      end
   end

endmodule

// File: tb/tb_axi_hp_wr_framer.sv
// Directed bench for axi_hp_wr_framer: bursts, frame end, flush, stalls, full, reset.
module tb_axi_hp_wr_framer;

   logic        clk = 1'b0;
   logic        i_rst;
   logic [63:0] S_IN_tdata;
   logic        S_IN_tvalid;
   logic        S_IN_tready;
   logic        i_flush;
   logic [63:0] M_WR_tdata;
   logic        M_WR_tvalid;
   logic        M_WR_tlast;
   logic        M_WR_tready;
   logic        o_wr_done;
   logic [4:0]  o_level;
   logic [15:0] o_burst_cnt;

   always #5 clk = ~clk;

   axi_hp_wr_framer #(
      .DATA_W       (64),
      .BURST_LEN    (4),
      .FIFO_DEPTH   (16),
      .FRAME_BURSTS (8),
      .PAD_WORD     (64'h0)
   ) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .S_IN_tdata  (S_IN_tdata),
      .S_IN_tvalid (S_IN_tvalid),
      .S_IN_tready (S_IN_tready),
      .i_flush     (i_flush),
      .M_WR_tdata  (M_WR_tdata),
      .M_WR_tvalid (M_WR_tvalid),
      .M_WR_tlast  (M_WR_tlast),
      .M_WR_tready (M_WR_tready),
      .o_wr_done   (o_wr_done),
      .o_level     (o_level),
      .o_burst_cnt (o_burst_cnt)
   );

   typedef struct {
      logic [63:0] d;
      logic        l;
      int          c;
   } beat_t;

   beat_t       bq[$];
   int          done_c[$];
   logic [15:0] done_bc[$];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_err = 0;

   // Inputs change on negedges, so values here are stable at the edge.
   always @(posedge clk) begin
      if (!i_rst && M_WR_tvalid && M_WR_tready) begin
         bq.push_back('{M_WR_tdata, M_WR_tlast, cyc});
      end
      if (o_wr_done) begin
         done_c.push_back(cyc);
         done_bc.push_back(o_burst_cnt);
      end
      cyc <= cyc + 1;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      i_rst       = 1'b1;
      S_IN_tvalid = 1'b0;
      i_flush     = 1'b0;
      tick();
      tick();
      chk("rst_sready", S_IN_tready, 0);
      chk("rst_tvalid", M_WR_tvalid, 0);
      chk("rst_level", o_level, 0);
      i_rst = 1'b0;
      tick();
      chk("rst_sready_after", S_IN_tready, 1);
      chk("rst_tvalid_after", M_WR_tvalid, 0);
      chk("rst_done", o_wr_done, 0);
      chk("rst_bcnt", o_burst_cnt, 0);
   endtask

   task automatic send(input logic [63:0] d);
      bit ok;
      ok          = 1'b0;
      S_IN_tdata  = d;
      S_IN_tvalid = 1'b1;
      for (int t = 0; t < 100 && !ok; t++) begin
         ok = S_IN_tready;
         tick();
      end
      if (!ok) chk("send_timeout", 0, 1);
   endtask

   task automatic wait_beats(input int n, input int base, input string tag);
      for (int t = 0; t < 300 && bq.size() < base + n; t++) tick();
      chk(tag, bq.size() - base, n);
   endtask

   task automatic wait_done(input int base, input string tag);
      for (int t = 0; t < 300 && done_c.size() <= base; t++) tick();
      repeat (4) tick();
      chk(tag, done_c.size() - base, 1);
   endtask

   task automatic chk_beats(input int base, input int n,
                            input logic [63:0] first, input string tag);
      for (int i = 0; i < n && base + i < bq.size(); i++) begin
         chk({tag, "_data"}, bq[base+i].d, first + 64'(i));
         chk({tag, "_last"}, bq[base+i].l, (i % 4) == 3);
      end
   endtask

   initial begin
      int          base;
      int          dbase;
      logic        pv;
      logic        pr;
      logic        pl;
      logic [63:0] pd;

      i_rst       = 1'b1;
      S_IN_tdata  = '0;
      S_IN_tvalid = 1'b0;
      i_flush     = 1'b0;
      M_WR_tready = 1'b1;

      // T1: one burst, exact latency
      do_reset();
      for (int i = 1; i <= 4; i++) send(64'(i));
      S_IN_tvalid = 1'b0;
      chk("t1_tvalid_k", M_WR_tvalid, 0);
      chk("t1_level_k", o_level, 4);
      tick();
      chk("t1_tvalid_k1", M_WR_tvalid, 1);
      for (int b = 0; b < 4; b++) begin
         chk("t1_data", M_WR_tdata, 64'(b + 1));
         chk("t1_last", M_WR_tlast, b == 3);
         tick();
      end
      chk("t1_tvalid_end", M_WR_tvalid, 0);
      chk("t1_level_end", o_level, 0);
      chk("t1_bcnt", o_burst_cnt, 1);

      // T2: full frame of 8 bursts
      do_reset();
      base  = bq.size();
      dbase = done_c.size();
      for (int i = 0; i < 32; i++) send(64'h100 + 64'(i));
      S_IN_tvalid = 1'b0;
      wait_done(dbase, "t2_done_cnt");
      chk("t2_beats", bq.size() - base, 32);
      chk_beats(base, 32, 64'h100, "t2");
      if (done_c.size() > dbase && bq.size() >= base + 32) begin
         chk("t2_done_cyc", done_c[dbase], bq[base+31].c + 1);
         chk("t2_done_bcnt", done_bc[dbase], 8);
      end else begin
         chk("t2_done_seen", 0, 1);
      end
      chk("t2_bcnt_after", o_burst_cnt, 0);
      chk("t2_level_after", o_level, 0);

      // T3: flush pads a partial burst
      do_reset();
      base  = bq.size();
      dbase = done_c.size();
      send(64'hAAAA);
      send(64'hBBBB);
      S_IN_tvalid = 1'b0;
      i_flush     = 1'b1;
      tick();
      i_flush = 1'b0;
      wait_done(dbase, "t3_done_cnt");
      chk("t3_beats", bq.size() - base, 4);
      if (bq.size() >= base + 4 && done_c.size() > dbase) begin
         chk("t3_d0", bq[base].d, 64'hAAAA);
         chk("t3_d1", bq[base+1].d, 64'hBBBB);
         chk("t3_d2", bq[base+2].d, 64'h0);
         chk("t3_d3", bq[base+3].d, 64'h0);
         chk("t3_l2", bq[base+2].l, 0);
         chk("t3_l3", bq[base+3].l, 1);
         chk("t3_done_cyc", done_c[dbase], bq[base+3].c + 1);
         chk("t3_done_bcnt", done_bc[dbase], 1);
      end
      chk("t3_bcnt_after", o_burst_cnt, 0);
      chk("t3_level_after", o_level, 0);

      // T4: tready toggling, output held while stalled
      do_reset();
      M_WR_tready = 1'b0;
      base = bq.size();
      for (int i = 0; i < 8; i++) send(64'h400 + 64'(i));
      S_IN_tvalid = 1'b0;
      pv = 1'b0;
      pr = 1'b0;
      pl = 1'b0;
      pd = '0;
      for (int t = 0; t < 80 && bq.size() < base + 8; t++) begin
         if (pv && !pr) begin
            chk("t4_hold_valid", M_WR_tvalid, 1);
            chk("t4_hold_data", M_WR_tdata, pd);
            chk("t4_hold_last", M_WR_tlast, pl);
         end
         pv          = M_WR_tvalid;
         pd          = M_WR_tdata;
         pl          = M_WR_tlast;
         pr          = ~M_WR_tready;
         M_WR_tready = pr;
         tick();
      end
      M_WR_tready = 1'b1;
      repeat (4) tick();
      chk("t4_beats", bq.size() - base, 8);
      chk_beats(base, 8, 64'h400, "t4");
      chk("t4_bcnt", o_burst_cnt, 2);

      // T5: fill to full with sink stalled, then drain
      do_reset();
      M_WR_tready = 1'b0;
      base  = bq.size();
      dbase = done_c.size();
      S_IN_tvalid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         S_IN_tdata = 64'h500 + 64'(c);
         tick();
      end
      chk("t5_level_full", o_level, 16);
      chk("t5_sready_full", S_IN_tready, 0);
      S_IN_tvalid = 1'b0;
      M_WR_tready = 1'b1;
      wait_beats(16, base, "t5_beats");
      chk_beats(base, 16, 64'h500, "t5");
      repeat (3) tick();
      chk("t5_extra_beats", bq.size() - base, 16);
      chk("t5_bcnt", o_burst_cnt, 4);
      chk("t5_no_done", done_c.size() - dbase, 0);
      chk("t5_level_after", o_level, 0);

      // T6: reset mid-burst, then a clean burst
      do_reset();
      M_WR_tready = 1'b1;
      base = bq.size();
      for (int i = 0; i < 4; i++) send(64'h600 + 64'(i));
      S_IN_tvalid = 1'b0;
      repeat (3) tick();
      chk("t6_beat2_data", M_WR_tdata, 64'h602);
      chk("t6_pre_beats", bq.size() - base, 2);
      i_rst = 1'b1;
      tick();
      chk("t6_rst_tvalid", M_WR_tvalid, 0);
      chk("t6_rst_level", o_level, 0);
      chk("t6_rst_bcnt", o_burst_cnt, 0);
      i_rst = 1'b0;
      tick();
      base = bq.size();
      for (int i = 0; i < 4; i++) send(64'h700 + 64'(i));
      S_IN_tvalid = 1'b0;
      wait_beats(4, base, "t6_beats");
      chk_beats(base, 4, 64'h700, "t6");
      tick();
      chk("t6_bcnt", o_burst_cnt, 1);
      chk("t6_level_after", o_level, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

endmodule
